// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//   Write-side loader for the instruction memory. Accepts a byte stream,
//   packs bytes little-endian into 32-bit words and issues one write strobe
//   per word at consecutive word-aligned byte addresses starting at
//   BASE_ADDR. busy stays high for the whole load so the core can be held
//   in reset.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     When defined, a running 32-bit sum of all written words is kept. After
//     the last word, four more bytes (little-endian) are received as the
//     expected sum, and chk_err reports a mismatch. When undefined, chk_err
//     is tied low and the last write goes straight to DONE.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start          1-cycle pulse, begins a load (ignored while busy)
//   num_words      words to load, clamped to MAX_WORDS (0 allowed)
//   byte_valid     source presents byte_data
//   byte_data      stream byte
//   byte_ready     loader accepts a byte (transfer on valid & ready)
//   wr_en          1-cycle write strobe
//   wr_addr        byte address of the write
//   wr_data        instruction word written
//   busy           high from start until completion
//   done           sticky completion flag, cleared by the next start
//   words_written  write strobes issued since the last start
//   chk_err        checksum mismatch (0 without LOADER_CHECKSUM_EN)
// ---------------------------------------------------------------------------
module instr_mem_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_WORDS  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           num_words,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           words_written,
  output logic                  chk_err
);

  localparam logic [15:0] LP_MAX_WORDS = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  state_t          r_state;
  logic [15:0]     r_n;
  logic [1:0]      r_lane;
  // Lower three bytes of the word being assembled; bytes shift in from the
  // top so that after three bytes lane 0 sits in bits [7:0].
  logic [23:0]     r_word;

  logic                  w_hs;
  logic [31:0]           w_word;
  logic [15:0]           w_n_clamp;
  logic [15:0]           w_ww_next;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_hs      = byte_valid & byte_ready;
  assign w_word    = {byte_data, r_word};
  assign w_n_clamp = (num_words > LP_MAX_WORDS) ? LP_MAX_WORDS : num_words;
  assign w_ww_next = words_written + 16'd1;
  assign w_addr    = BASE_ADDR + ADDR_WIDTH'({words_written, 2'b00});

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] r_sum;
`else
  assign chk_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_n           <= '0;
      r_lane        <= '0;
      r_word        <= '0;
      byte_ready    <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= BASE_ADDR;
      wr_data       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      words_written <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_sum         <= '0;
      chk_err       <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_n           <= w_n_clamp;
            done          <= 1'b0;
            words_written <= '0;
            r_lane        <= '0;
            busy          <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            r_sum         <= '0;
            chk_err       <= 1'b0;
`endif
            if (w_n_clamp == '0) begin
              // Empty load: one cycle in DONE with busy still high, then
              // the DONE branch below drops busy and raises done.
              r_state    <= S_DONE;
              byte_ready <= 1'b0;
            end else begin
              r_state    <= S_RECV;
              byte_ready <= 1'b1;
            end
          end else if (r_state == S_DONE) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end

        S_RECV: begin
          if (w_hs) begin
            r_word <= {byte_data, r_word[23:8]};
            r_lane <= r_lane + 2'd1;
            if (r_lane == 2'd3) begin
              r_state    <= S_WRITE;
              byte_ready <= 1'b0;
              wr_en      <= 1'b1;
              wr_data    <= w_word;
              wr_addr    <= w_addr;
`ifdef LOADER_CHECKSUM_EN
              r_sum      <= r_sum + w_word;
`endif
            end
          end
        end

        S_WRITE: begin
          words_written <= w_ww_next;
          r_lane        <= '0;
          byte_ready    <= 1'b1;
          if (w_ww_next == r_n) begin
`ifdef LOADER_CHECKSUM_EN
            r_state    <= S_CHK;
`else
            r_state    <= S_DONE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
`endif
          end else begin
            r_state <= S_RECV;
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_hs) begin
            r_word <= {byte_data, r_word[23:8]};
            r_lane <= r_lane + 2'd1;
            if (r_lane == 2'd3) begin
              chk_err    <= (w_word != r_sum);
              r_state    <= S_DONE;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
`endif

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_words;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [15:0] words_written;
  logic        chk_err;

  always #5 clk = ~clk;

  instr_mem_loader #(
    .ADDR_WIDTH(32),
    .BASE_ADDR (32'h0),
    .MAX_WORDS (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_words    (num_words),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .words_written(words_written),
    .chk_err      (chk_err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] tb_sum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endtask

  // Monitor: every write strobe is matched against the scoreboard.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write",
                   wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
          check("ready_low_in_write", 32'(byte_ready), 32'd0);
        end
      end
    end
  end

  task automatic do_start(input logic [15:0] n, input logic with_byte);
    @(negedge clk);
    start      = 1'b1;
    num_words  = n;
    byte_valid = with_byte;
    byte_data  = 8'hFF;
    @(negedge clk);
    start      = 1'b0;
    byte_valid = 1'b0;
    tb_sum     = '0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int cnt;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    cnt = 0;
    while (byte_ready !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (byte_ready !== 1'b1) begin
      timeout_fail("byte_ready_wait");
      byte_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int idx, input int gap);
    exp_q.push_back({32'(idx * 4), w});
    tb_sum += w;
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    // Write strobe must appear in the cycle right after the 4th handshake.
    @(negedge clk);
    check("wr_en_latency", 32'(wr_en), 32'd1);
  endtask

  task automatic send_chk(input logic [31:0] s);
`ifdef LOADER_CHECKSUM_EN
    for (int i = 0; i < 4; i++) send_byte(s[8*i +: 8], 0);
`else
    if (s === 32'hx) $display("checksum byte stream not used in this build");
`endif
  endtask

  task automatic wait_done(input string name);
    int cnt;
    cnt = 0;
    while (done !== 1'b1 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    if (done !== 1'b1) timeout_fail(name);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    num_words  = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    tb_sum     = '0;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_words", 32'(words_written), 32'd0);
    check("rst_chk_err", 32'(chk_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1) two words back to back
    do_start(16'd2, 1'b0);
    check("t1_ready_in_recv", 32'(byte_ready), 32'd1);
    send_word(32'h0000_0013, 0, 0);
    send_word(32'h0010_0093, 1, 0);
    send_chk(tb_sum);
    wait_done("t1_done");
    check("t1_done", 32'(done), 32'd1);
    check("t1_words", 32'(words_written), 32'd2);
    check("t1_hold_addr", wr_addr, 32'd4);
    check("t1_hold_data", wr_data, 32'h0010_0093);

    // 2) one word with gaps; start coincides with a valid byte that must be ignored
    do_start(16'd1, 1'b1);
    send_word(32'hCAFE_F00D, 0, 3);
    send_chk(tb_sum);
    wait_done("t2_done");
    check("t2_words", 32'(words_written), 32'd1);

    // 3) empty load, then clamped load of 70 -> 64
    do_start(16'd0, 1'b0);
    check("t3_done_low", 32'(done), 32'd0);
    @(negedge clk);
    check("t3_busy_one_cycle", 32'(busy), 32'd0);
    check("t3_done_set", 32'(done), 32'd1);
    check("t3_words_zero", 32'(words_written), 32'd0);
    do_start(16'd70, 1'b0);
    for (int i = 0; i < 64; i++) send_word(32'h1000_0000 + 32'(i) * 32'h0001_0203, i, 0);
    send_chk(tb_sum);
    wait_done("t3_done");
    check("t3_words_64", 32'(words_written), 32'd64);
    check("t3_last_addr", wr_addr, 32'd252);

    // 4) reset in the middle of a word
    do_start(16'd2, 1'b0);
    send_byte(8'h44, 0);
    send_byte(8'h33, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_ready", 32'(byte_ready), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    check("t4_wr_addr", wr_addr, 32'd0);
    check("t4_wr_data", wr_data, 32'd0);
    check("t4_words", 32'(words_written), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start(16'd1, 1'b0);
    send_word(32'hDEAD_BEEF, 0, 0);
    send_chk(tb_sum);
    wait_done("t4_done");
    check("t4_words_after", 32'(words_written), 32'd1);

    // 5) start while busy is ignored; start from DONE begins a new load
    do_start(16'd2, 1'b0);
    send_word(32'hA5A5_0001, 0, 0);
    @(negedge clk);
    start     = 1'b1;
    num_words = 16'd1;
    @(negedge clk);
    start     = 1'b0;
    check("t5_busy_kept", 32'(busy), 32'd1);
    send_word(32'h5A5A_0002, 1, 0);
    send_chk(tb_sum);
    wait_done("t5_done");
    check("t5_words", 32'(words_written), 32'd2);
    do_start(16'd1, 1'b0);
    check("t5_done_cleared", 32'(done), 32'd0);
    check("t5_words_cleared", 32'(words_written), 32'd0);
    send_word(32'h0BAD_C0DE, 0, 0);
    send_chk(tb_sum);
    wait_done("t5_done2");
    check("t5_words2", 32'(words_written), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // 6) checksum good, then bad
    do_start(16'd2, 1'b0);
    send_word(32'h1, 0, 0);
    send_word(32'h2, 1, 0);
    send_chk(32'h3);
    wait_done("t6_done_ok");
    check("t6_chk_ok", 32'(chk_err), 32'd0);
    do_start(16'd2, 1'b0);
    send_word(32'h1, 0, 0);
    send_word(32'h2, 1, 0);
    send_chk(32'h4);
    wait_done("t6_done_bad");
    check("t6_chk_bad", 32'(chk_err), 32'd1);
    check("t6_done", 32'(done), 32'd1);
`endif

    repeat (3) @(negedge clk);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
